// File: rtl/uart_imem_loader_if.sv
// uart_imem_loader_if: instruction-memory write port from the UART loader.
// master drives imem_we/imem_addr/imem_wdata; slave is the imem side.
interface uart_imem_loader_if #(
   parameter int IMEM_ADDR_WIDTH = 10
);
   logic                       imem_we;
   logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]                imem_wdata;

   modport master (
      output imem_we,
      output imem_addr,
      output imem_wdata
   );

   modport slave (
      input imem_we,
      input imem_addr,
      input imem_wdata
   );
endinterface

// File: rtl/uart_imem_loader.sv
// uart_imem_loader: loads a program image from an 8N1 UART into imem
// and holds the CPU pipeline in reset until a load completes.
// Ports: clk, rst (sync, active high), rx (async serial line),
//   imem (write port: imem_we/imem_addr/imem_wdata), cpu_rst,
//   busy (load in progress), done (completion pulse), error (sticky).
// Frame: A5, N[7:0], N[15:8], N words as 4 LE bytes each.
// Define UART_IMEM_LOADER_CHECKSUM_EN to require a trailing XOR byte.
module uart_imem_loader #(
   parameter int CLKS_PER_BIT    = 868,
   parameter int IMEM_ADDR_WIDTH = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx,
   uart_imem_loader_if.master imem,
   output logic               cpu_rst,
   output logic               busy,
   output logic               done,
   output logic               error
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [16:0] DEPTH = 17'd1 << IMEM_ADDR_WIDTH;
   localparam logic [7:0]  SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {
      RX_IDLE, RX_START, RX_DATA, RX_STOP
   } rx_state_t;

   typedef enum logic [2:0] {
      L_SYNC, L_LEN0, L_LEN1, L_DATA
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
      , L_CSUM
`endif
   } ld_state_t;

   // ---------------- rx synchronizer ----------------
   logic rx_q1, rx_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_q1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         rx_q1 <= rx;
         rx_s  <= rx_q1;
      end
   end

   // ---------------- rx fsm ----------------
   rx_state_t     rx_state, rx_next;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    rx_byte;
   logic          half_tick, full_tick;
   logic          byte_valid, frame_err;

   assign half_tick = rx_cnt == CW'(CLKS_PER_BIT / 2 - 1);
   assign full_tick = rx_cnt == CW'(CLKS_PER_BIT - 1);

   always_ff @(posedge clk) begin
      if (rst) rx_state <= RX_IDLE;
      else     rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      unique case (rx_state)
         RX_IDLE:  if (!rx_s) rx_next = RX_START;
         RX_START: if (half_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:  if (full_tick && bit_idx == 3'd7) rx_next = RX_STOP;
         RX_STOP:  if (full_tick) rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      if (rx_state == RX_STOP && full_tick) begin
         byte_valid = rx_s;
         frame_err  = !rx_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_cnt  <= '0;
         bit_idx <= '0;
         rx_byte <= '0;
      end else begin
         unique case (rx_state)
            RX_IDLE: begin
               rx_cnt  <= '0;
               bit_idx <= '0;
            end
            RX_START: rx_cnt <= half_tick ? '0 : rx_cnt + 1'b1;
            RX_DATA: begin
               rx_cnt <= full_tick ? '0 : rx_cnt + 1'b1;
               if (full_tick) begin
                  rx_byte <= {rx_s, rx_byte[7:1]};
                  bit_idx <= bit_idx + 3'd1;
               end
            end
            RX_STOP: rx_cnt <= full_tick ? '0 : rx_cnt + 1'b1;
            default: rx_cnt <= '0;
         endcase
      end
   end

   // ---------------- loader fsm ----------------
   ld_state_t ld_state, ld_next;
   logic [7:0]  len_lo;
   logic [15:0] len, n_word, word_idx;
   logic [1:0]  byte_cnt;
   logic [23:0] wbuf;
   logic        len_zero, len_big, last_word;
   logic        sync_hit, len_lo_we, len_we, data_byte;
   logic        wr_word, finish, fail;
   logic        we_q, done_q;
   logic [IMEM_ADDR_WIDTH-1:0] addr_q;
   logic [31:0] wdata_q;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   assign n_word    = {rx_byte, len_lo};
   assign len_zero  = n_word == 16'd0;
   assign len_big   = {1'b0, n_word} > DEPTH;
   assign last_word = word_idx == len - 16'd1;

   always_ff @(posedge clk) begin
      if (rst) ld_state <= L_SYNC;
      else     ld_state <= ld_next;
   end

   always_comb begin
      ld_next = ld_state;
      if (frame_err) begin
         ld_next = L_SYNC;
      end else if (byte_valid) begin
         unique case (ld_state)
            L_SYNC: if (rx_byte == SYNC_BYTE) ld_next = L_LEN0;
            L_LEN0: ld_next = L_LEN1;
            L_LEN1: ld_next = (len_zero || len_big) ? L_SYNC : L_DATA;
            L_DATA: if (byte_cnt == 2'd3 && last_word)
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
               ld_next = L_CSUM;
            L_CSUM: ld_next = L_SYNC;
`else
               ld_next = L_SYNC;
`endif
            default: ld_next = L_SYNC;
         endcase
      end
   end

   always_comb begin
      sync_hit  = 1'b0;
      len_lo_we = 1'b0;
      len_we    = 1'b0;
      data_byte = 1'b0;
      wr_word   = 1'b0;
      finish    = 1'b0;
      fail      = frame_err;
      if (byte_valid) begin
         unique case (ld_state)
            L_SYNC: sync_hit = rx_byte == SYNC_BYTE;
            L_LEN0: len_lo_we = 1'b1;
            L_LEN1: begin
               len_we = 1'b1;
               finish = len_zero;
               fail   = len_big;
            end
            L_DATA: begin
               data_byte = 1'b1;
               wr_word   = byte_cnt == 2'd3;
`ifndef UART_IMEM_LOADER_CHECKSUM_EN
               finish    = wr_word && last_word;
`endif
            end
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            L_CSUM: begin
               finish = rx_byte == csum;
               fail   = rx_byte != csum;
            end
`endif
            default: ;
         endcase
      end
   end

   // Write strobe, done and cpu_rst release all land one cycle after
   // the deciding byte_valid, so done coincides with the last write.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q     <= 1'b0;
         done_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cpu_rst  <= 1'b1;
         error    <= 1'b0;
         len_lo   <= '0;
         len      <= '0;
         word_idx <= '0;
         byte_cnt <= '0;
         wbuf     <= '0;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
         csum     <= '0;
`endif
      end else begin
         we_q   <= wr_word;
         done_q <= finish;
         if (sync_hit) begin
            error    <= 1'b0;
            cpu_rst  <= 1'b1;
            word_idx <= '0;
            byte_cnt <= '0;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
         end
         if (len_lo_we) len_lo <= rx_byte;
         if (len_we)    len    <= n_word;
         if (data_byte) begin
            byte_cnt <= byte_cnt + 2'd1;
            wbuf     <= {rx_byte, wbuf[23:8]};
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_byte;
`endif
         end
         if (wr_word) begin
            addr_q   <= word_idx[IMEM_ADDR_WIDTH-1:0];
            wdata_q  <= {rx_byte, wbuf};
            word_idx <= word_idx + 16'd1;
         end
         if (finish) cpu_rst <= 1'b0;
         if (fail)   error   <= 1'b1;
      end
   end

   assign imem.imem_we    = we_q;
   assign imem.imem_addr  = addr_q;
   assign imem.imem_wdata = wdata_q;
   assign done = done_q;
   assign busy = ld_state != L_SYNC;
endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader: directed UART load frames against uart_imem_loader.
// Expected words, checksums and pulse counts are hand-computed.
module tb_uart_imem_loader;
   localparam int CPB = 4;
   localparam int AW  = 10;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;
   logic cpu_rst, busy, done, error;

   uart_imem_loader_if #(.IMEM_ADDR_WIDTH(AW)) imem ();

   uart_imem_loader #(
      .CLKS_PER_BIT(CPB),
      .IMEM_ADDR_WIDTH(AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .imem(imem),
      .cpu_rst(cpu_rst),
      .busy(busy),
      .done(done),
      .error(error)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int we_cnt = 0;
   int done_cnt = 0;
   int cyc = 0;
   int last_we_cyc = 0;
   int done_cyc = 0;
   logic [31:0] mem [0:(1<<AW)-1];

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (imem.imem_we === 1'b1) begin
         mem[imem.imem_addr] = imem.imem_wdata;
         we_cnt = we_cnt + 1;
         last_we_cyc = cyc;
      end
      if (done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic send_seq(input bq_t s);
      foreach (s[i]) send_frame(s[i], 1'b1);
   endtask

   task automatic clr();
      we_cnt   = 0;
      done_cnt = 0;
   endtask

   bq_t s;

   initial begin
      repeat (4) @(negedge clk);
      chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);
      chk("rst_we", {31'd0, imem.imem_we}, 32'd0);
      chk("rst_addr", 32'(imem.imem_addr), 32'd0);
      chk("rst_wdata", imem.imem_wdata, 32'd0);
      rst = 1'b0;
      clr();
      repeat (1000) @(negedge clk);
      chk("idle_we", we_cnt, 0);
      chk("idle_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_error", {31'd0, error}, 32'd0);

      // two-word load
      clr();
      s = {8'hA5, 8'h02};
      send_seq(s);
      chk("l1_busy", {31'd0, busy}, 32'd1);
      s = {8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
      s.push_back(8'h90);
`endif
      send_seq(s);
      chk("l1_we_cnt", we_cnt, 2);
      chk("l1_done_cnt", done_cnt, 1);
      chk("l1_mem0", mem[0], 32'h0000_0013);
      chk("l1_mem1", mem[1], 32'h0010_0093);
      chk("l1_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      chk("l1_busy_end", {31'd0, busy}, 32'd0);
      chk("l1_error", {31'd0, error}, 32'd0);
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
      chk("l1_done_after", {31'd0, done_cyc > last_we_cyc}, 32'd1);
`else
      chk("l1_done_with_we", done_cyc, last_we_cyc);
`endif

      // junk before sync, then one word
      clr();
      s = {8'h11, 8'h22};
      send_seq(s);
      chk("l2_junk_busy", {31'd0, busy}, 32'd0);
      chk("l2_junk_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      s = {8'hA5};
      send_seq(s);
      chk("l2_resync_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      s = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
      s.push_back(8'h22);
`endif
      send_seq(s);
      chk("l2_mem0", mem[0], 32'hDEAD_BEEF);
      chk("l2_we_cnt", we_cnt, 1);
      chk("l2_done_cnt", done_cnt, 1);
      chk("l2_cpu_rst", {31'd0, cpu_rst}, 32'd0);

      // N = 1025 exceeds 1024-word imem
      clr();
      s = {8'hA5, 8'h01, 8'h04};
      send_seq(s);
      chk("big_error", {31'd0, error}, 32'd1);
      chk("big_we_cnt", we_cnt, 0);
      chk("big_done_cnt", done_cnt, 0);
      chk("big_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      chk("big_busy", {31'd0, busy}, 32'd0);
      s = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
      s.push_back(8'h08);
`endif
      send_seq(s);
      chk("big_recover_error", {31'd0, error}, 32'd0);
      chk("big_recover_mem0", mem[0], 32'h1234_5678);
      chk("big_recover_cpu_rst", {31'd0, cpu_rst}, 32'd0);

      // framing error in the middle of a word
      clr();
      s = {8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
      send_seq(s);
      send_frame(8'hCC, 1'b0);
      repeat (20 * CPB) @(negedge clk);
      chk("ferr_error", {31'd0, error}, 32'd1);
      chk("ferr_busy", {31'd0, busy}, 32'd0);
      chk("ferr_we_cnt", we_cnt, 0);
      chk("ferr_cpu_rst", {31'd0, cpu_rst}, 32'd1);

      // one-clock low glitch between data bytes must not add a byte
      clr();
      s = {8'hA5, 8'h01, 8'h00, 8'h01, 8'h02};
      send_seq(s);
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (10 * CPB) @(negedge clk);
      s = {8'h03, 8'h04};
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
      s.push_back(8'h04);
`endif
      send_seq(s);
      chk("glitch_mem0", mem[0], 32'h0403_0201);
      chk("glitch_we_cnt", we_cnt, 1);
      chk("glitch_error", {31'd0, error}, 32'd0);
      chk("glitch_done_cnt", done_cnt, 1);

      // reset after 2 of 4 bytes of word 0
      clr();
      s = {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
      send_seq(s);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("mrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      chk("mrst_error", {31'd0, error}, 32'd0);
      rst = 1'b0;
      s = {8'h33, 8'h44};
      send_seq(s);
      chk("mrst_we_cnt", we_cnt, 0);
      chk("mrst_done_cnt", done_cnt, 0);
      chk("mrst_busy_after", {31'd0, busy}, 32'd0);

`ifdef UART_IMEM_LOADER_CHECKSUM_EN
      // wrong checksum: 0x55 sent, 0x01 expected
      clr();
      s = {8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h55};
      send_seq(s);
      chk("csum_error", {31'd0, error}, 32'd1);
      chk("csum_done_cnt", done_cnt, 0);
      chk("csum_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      chk("csum_we_cnt", we_cnt, 1);
      chk("csum_mem0", mem[0], 32'h0000_0001);
`endif

      // N = 0 completes immediately
      clr();
      s = {8'hA5, 8'h00, 8'h00};
      send_seq(s);
      chk("n0_done_cnt", done_cnt, 1);
      chk("n0_we_cnt", we_cnt, 0);
      chk("n0_cpu_rst", {31'd0, cpu_rst}, 32'd0);
      chk("n0_error", {31'd0, error}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
